// File: rtl/caliptra_prim_alert_receiver.sv
// Receiver side of the differential alert protocol.
// Decodes alert_p/alert_n from one sender, runs the four-phase ack handshake,
// issues ping requests, and reports alerts, ping answers and integrity
// failures as single-cycle pulses.
// Optional build macro: CALIPTRA_ALERT_RX_INTEG_STICKY_EN makes integ_fail_o
// a sticky level that only rst_i clears.
// Bit order: alert_tx_i = {alert_p, alert_n},
//            alert_rx_o = {ping_p, ping_n, ack_p, ack_n}.

module caliptra_prim_alert_receiver #(
  parameter bit AsyncOn = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ping_req_i,
  output logic       ping_ok_o,
  output logic       alert_o,
  output logic       integ_fail_o,
  input  logic [1:0] alert_tx_i,
  output logic [3:0] alert_rx_o
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StHsAckWait = 2'd1;
  localparam logic [1:0] StPause0    = 2'd2;
  localparam logic [1:0] StPause1    = 2'd3;

  logic [1:0] w_alertSync;
  logic       w_alertHigh;
  logic       w_alertLow;
  logic       w_integFail;
  logic [1:0] w_stateNext;
  logic       w_hsStart;
  logic       w_pingRise;

  logic [1:0] r_state;
  logic       r_ackP;
  logic       r_ackN;
  logic       r_pingP;
  logic       r_pingN;
  logic       r_pingReq;
  logic       r_pingReqD;
  logic       r_pingPending;

  // The input stage resets to the "alert low" encoding so that reset itself
  // never looks like an integrity failure.
  if (AsyncOn) begin : gen_async
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;

    // Two-flop synchronizer for a sender on a foreign clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_sync1 <= 2'b01;
        r_sync2 <= 2'b01;
      end else begin
        r_sync1 <= alert_tx_i;
        r_sync2 <= r_sync1;
      end
    end

    assign w_alertSync = r_sync2;
  end else begin : gen_sync
    logic [1:0] r_sync1;

    // Single capture register for a sender sharing clk_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_sync1 <= 2'b01;
      end else begin
        r_sync1 <= alert_tx_i;
      end
    end

    assign w_alertSync = r_sync1;
  end

  assign w_alertHigh = w_alertSync[1] & ~w_alertSync[0];
  assign w_alertLow  = ~w_alertSync[1] & w_alertSync[0];
  assign w_integFail = (w_alertSync[1] == w_alertSync[0]);

  // Ping edge uses two registered copies so the toggle lands one edge after
  // the request is captured.
  assign w_pingRise = r_pingReq & ~r_pingReqD;

  // Next-state logic; an integrity failure overrides everything, including
  // a handshake that would otherwise start this cycle.
  always_comb begin
    w_stateNext = r_state;
    w_hsStart   = 1'b0;
    if (w_integFail) begin
      w_stateNext = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_alertHigh) begin
            w_stateNext = StHsAckWait;
            w_hsStart   = 1'b1;
          end
        end
        StHsAckWait: begin
          if (w_alertLow) begin
            w_stateNext = StPause0;
          end
        end
        StPause0: w_stateNext = StPause1;
        StPause1: w_stateNext = StIdle;
        default:  w_stateNext = StIdle;
      endcase
    end
  end

  // State register and ack pair; ack is high exactly while waiting in
  // HsAckWait, and the two ack flops always hold complementary values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_ackP  <= 1'b0;
      r_ackN  <= 1'b1;
    end else begin
      r_state <= w_stateNext;
      r_ackP  <= (w_stateNext == StHsAckWait);
      r_ackN  <= (w_stateNext != StHsAckWait);
    end
  end

  // Ping request tracking: toggle the ping pair once per request and remember
  // that an answer is owed until it arrives or the request is withdrawn.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pingReq     <= 1'b0;
      r_pingReqD    <= 1'b0;
      r_pingPending <= 1'b0;
      r_pingP       <= 1'b0;
      r_pingN       <= 1'b1;
    end else begin
      r_pingReq  <= ping_req_i;
      r_pingReqD <= r_pingReq;
      if (!r_pingReq) begin
        r_pingPending <= 1'b0;
      end else if (w_hsStart && r_pingPending) begin
        r_pingPending <= 1'b0;
      end else if (w_pingRise) begin
        r_pingPending <= 1'b1;
      end
      if (w_pingRise && !r_pingPending) begin
        r_pingP <= ~r_pingP;
        r_pingN <= ~r_pingN;
      end
    end
  end

  // Event outputs: a handshake start is classified as a ping answer when one
  // is owed, otherwise as a genuine alert.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ping_ok_o    <= 1'b0;
      alert_o      <= 1'b0;
      integ_fail_o <= 1'b0;
    end else begin
      ping_ok_o <= w_hsStart & r_pingPending;
      alert_o   <= w_hsStart & ~r_pingPending;
`ifdef CALIPTRA_ALERT_RX_INTEG_STICKY_EN
      integ_fail_o <= integ_fail_o | w_integFail;
`else
      integ_fail_o <= w_integFail;
`endif
    end
  end

  assign alert_rx_o = {r_pingP, r_pingN, r_ackP, r_ackN};

endmodule
